pipe_if_id_reg: RTL and testbench
=================================

// Module: pipe_if_id_reg
// PURPOSE
//   IF/ID pipeline register. Captures the fetch stage's pc, pc4 and ins outputs
//   each clock and presents them to decode as id_pc, id_pc4 and id_ins.
//   Supports stall (hold contents), flush (insert a bubble on a taken branch or jump),
//   and a valid bit. Holds saturating stall/flush event counters and a sticky stall
//   watchdog, read by debug.
// PARAMETERS
//   PC_W       8    program-counter width (byte address)
//   INS_W      32   instruction width
//   CNT_W      16   width of the stall_cnt and flush_cnt counters
//   MAX_STALL  15   consecutive stall cycles that set stall_timeout (must be >= 1)
// PORTS
//   clock          in   1      single clock, all state changes on posedge
//   resetn         in   1      synchronous reset, active-low
//   if_pc          in   PC_W   pc of the fetched instruction
//   if_pc4         in   PC_W   if_pc+4 from fetch
//   if_ins         in   INS_W  fetched instruction word
//   if_valid       in   1      fetch output holds a real instruction
//   stall          in   1      hold IF/ID contents (load-use hazard)
//   flush          in   1      discard the captured instruction (taken branch or jump)
//   id_pc          out  PC_W   registered pc
//   id_pc4         out  PC_W   registered pc4
//   id_ins         out  INS_W  registered instruction (0 = NOP when bubble)
//   id_valid       out  1      id_ins is a real instruction
//   id_state       out  2      FSM state: 0 EMPTY, 1 FULL, 2 HELD
//   stall_cnt      out  CNT_W  cycles in which a stall was applied (saturating)
//   flush_cnt      out  CNT_W  flush events (saturating)
//   stall_timeout  out  1      sticky: stall run reached MAX_STALL
// BEHAVIOUR
//   - All updates on posedge clock. Priority: reset > flush > stall > load.
//   - Reset (resetn=0 at the edge) sets all outputs to 0 and id_state to EMPTY;
//     the stall run counter is cleared. Reset mid-stall or mid-flush wins; nothing is retained.
//   - Load (flush=0, stall=0): the next cycle id_pc=if_pc, id_pc4=if_pc4, id_ins=if_ins
//     and id_valid=if_valid. The stall run counter clears. Latency is 1 cycle.
//   - Flush (flush=1, regardless of stall): id_ins=0, id_valid=0, id_pc=0, id_pc4=0.
//     flush_cnt increments. The stall run counter clears, and a simultaneous stall is not counted.
//   - Stall (stall=1, flush=0): id_pc, id_pc4, id_ins and id_valid hold.
//     stall_cnt increments, also when holding a bubble. The stall run counter increments
//     and saturates at MAX_STALL.
//   - stall_timeout is set at the edge where the run counter becomes MAX_STALL.
//     It stays 1 until reset.
//   - Counters saturate at 2^CNT_W-1 and never wrap.
//   - FSM, evaluated from the next-state values:
//       next id_valid=0 -> EMPTY
//       stall applied and next id_valid=1 -> HELD
//       otherwise -> FULL
//     Transitions:
//       EMPTY -> FULL on a load with if_valid=1
//       FULL  -> HELD on stall
//       HELD  -> FULL on a load with if_valid=1; HELD -> EMPTY on flush, or on a load with if_valid=0
//       any   -> EMPTY on flush or reset
//   - id_ins and id_valid are glitch-free register outputs; no combinational path runs from input to output.
// TESTING
//   1 Reset: drive resetn=0 for 2 cycles with if_ins=32'hDEADBEEF. Expect all outputs 0, id_state=0.
//     After release with stall=0, id_ins=32'hDEADBEEF one cycle later.
//   2 Stream: feed pc 0,4,8 with distinct ins and if_valid=1. Expect each id_ins one cycle
//     after it is presented, id_pc4=pc+4, and id_state=FULL.
//   3 Stall: while holding ins 32'h8C010004, assert stall for 3 cycles. id_ins stays 32'h8C010004,
//     id_state=HELD, and stall_cnt=3. When stall drops, the next fetch loads.
//   4 Flush with stall: assert flush=1 and stall=1 in the same cycle. Expect id_ins=0, id_valid=0,
//     id_state=EMPTY, flush_cnt+1, and no stall_cnt change.
//   5 Watchdog: hold stall=1 for MAX_STALL=15 cycles. stall_timeout rises at the 15th edge and stays 1
//     after stall drops. Only resetn=0 clears it.
//   6 Saturation: with CNT_W=2, apply 5 stalls. stall_cnt sticks at 3.

Source files
------------

// File: rtl/pipe_if_id_reg.sv
// IF/ID pipeline register with stall/flush control, occupancy FSM,
// saturating stall/flush event counters and a sticky stall watchdog.
module pipe_if_id_reg #(
   parameter int unsigned PC_W      = 8,
   parameter int unsigned INS_W     = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 15
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [PC_W-1:0]  if_pc,
   input  logic [PC_W-1:0]  if_pc4,
   input  logic [INS_W-1:0] if_ins,
   input  logic             if_valid,
   input  logic             stall,
   input  logic             flush,
   output logic [PC_W-1:0]  id_pc,
   output logic [PC_W-1:0]  id_pc4,
   output logic [INS_W-1:0] id_ins,
   output logic             id_valid,
   output logic [1:0]       id_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             stall_timeout
);

   localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HELD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    pc4_q, pc4_d;
   logic [INS_W-1:0]   ins_q, ins_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               timeout_q, timeout_d;
   logic               hold;

   // A stall only takes effect when no flush overrides it.
   assign hold = stall & ~flush;

   // Datapath, counters and watchdog next-state.
   always_comb begin
      pc_d        = pc_q;
      pc4_d       = pc4_q;
      ins_d       = ins_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      run_d       = '0;
      if (flush) begin
         pc_d    = '0;
         pc4_d   = '0;
         ins_d   = '0;
         valid_d = 1'b0;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (stall) begin
         if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
      end else begin
         pc_d    = if_pc;
         pc4_d   = if_pc4;
         ins_d   = if_ins;
         valid_d = if_valid;
      end
      timeout_d = timeout_q | (run_d == RUN_MAX);
   end

   // Occupancy FSM next-state, derived from the next valid bit.
   always_comb begin
      state_d = ST_FULL;
      if (!valid_d)  state_d = ST_EMPTY;
      else if (hold) state_d = ST_HELD;
   end

   always_ff @(posedge clock) begin
      if (!resetn) state_q <= ST_EMPTY;
      else         state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         pc_q        <= '0;
         pc4_q       <= '0;
         ins_q       <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         run_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         pc4_q       <= pc4_d;
         ins_q       <= ins_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         run_q       <= run_d;
         timeout_q   <= timeout_d;
      end
   end

   assign id_pc         = pc_q;
   assign id_pc4        = pc4_q;
   assign id_ins        = ins_q;
   assign id_valid      = valid_q;
   assign id_state      = state_q;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;
   assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_if_id_reg.sv
// Directed bench for pipe_if_id_reg: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_pipe_if_id_reg;

   logic        clock = 1'b0;
   logic        resetn;
   logic [7:0]  if_pc, if_pc4;
   logic [31:0] if_ins;
   logic        if_valid, stall, flush;

   logic [7:0]  id_pc, id_pc4;
   logic [31:0] id_ins;
   logic        id_valid;
   logic [1:0]  id_state;
   logic [15:0] stall_cnt, flush_cnt;
   logic        stall_timeout;

   logic [7:0]  s_pc, s_pc4;
   logic [31:0] s_ins;
   logic        s_valid;
   logic [1:0]  s_state;
   logic [1:0]  s_stall_cnt, s_flush_cnt;
   logic        s_timeout;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   pipe_if_id_reg dut (
      .clock(clock), .resetn(resetn), .if_pc(if_pc), .if_pc4(if_pc4),
      .if_ins(if_ins), .if_valid(if_valid), .stall(stall), .flush(flush),
      .id_pc(id_pc), .id_pc4(id_pc4), .id_ins(id_ins), .id_valid(id_valid),
      .id_state(id_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .stall_timeout(stall_timeout)
   );

   pipe_if_id_reg #(.CNT_W(2)) dut_sat (
      .clock(clock), .resetn(resetn), .if_pc(if_pc), .if_pc4(if_pc4),
      .if_ins(if_ins), .if_valid(if_valid), .stall(stall), .flush(flush),
      .id_pc(s_pc), .id_pc4(s_pc4), .id_ins(s_ins), .id_valid(s_valid),
      .id_state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
      .stall_timeout(s_timeout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input logic [7:0] pc, input logic [31:0] ins, input logic v);
      if_pc    = pc;
      if_pc4   = pc + 8'd4;
      if_ins   = ins;
      if_valid = v;
   endtask

   initial begin
      resetn = 1'b0; stall = 1'b0; flush = 1'b0;
      fetch(8'h10, 32'hDEADBEEF, 1'b1);

      // 1: reset
      tick(); tick();
      chk("rst_ins", 64'(id_ins), 64'h0);
      chk("rst_valid", 64'(id_valid), 64'h0);
      chk("rst_pc", 64'(id_pc), 64'h0);
      chk("rst_pc4", 64'(id_pc4), 64'h0);
      chk("rst_state", 64'(id_state), 64'h0);
      chk("rst_scnt", 64'(stall_cnt), 64'h0);
      chk("rst_fcnt", 64'(flush_cnt), 64'h0);
      chk("rst_tmo", 64'(stall_timeout), 64'h0);
      resetn = 1'b1;
      tick();
      chk("rel_ins", 64'(id_ins), 64'hDEADBEEF);
      chk("rel_pc", 64'(id_pc), 64'h10);
      chk("rel_state", 64'(id_state), 64'h1);

      // 2: stream
      fetch(8'h00, 32'h20010001, 1'b1); tick();
      chk("s0_ins", 64'(id_ins), 64'h20010001);
      chk("s0_pc4", 64'(id_pc4), 64'h04);
      chk("s0_state", 64'(id_state), 64'h1);
      fetch(8'h04, 32'h20020002, 1'b1); tick();
      chk("s1_ins", 64'(id_ins), 64'h20020002);
      chk("s1_pc4", 64'(id_pc4), 64'h08);
      fetch(8'h08, 32'h8C010004, 1'b1); tick();
      chk("s2_ins", 64'(id_ins), 64'h8C010004);
      chk("s2_pc", 64'(id_pc), 64'h08);
      chk("s2_pc4", 64'(id_pc4), 64'h0C);
      chk("s2_valid", 64'(id_valid), 64'h1);

      // 3: stall 3 cycles while fetch presents the next word
      fetch(8'h0C, 32'hAAAA0000, 1'b1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_ins", 64'(id_ins), 64'h8C010004);
         chk("st_state", 64'(id_state), 64'h2);
      end
      chk("st_cnt", 64'(stall_cnt), 64'h3);
      chk("st_sat_cnt", 64'(s_stall_cnt), 64'h3);
      stall = 1'b0; tick();
      chk("st_rel_ins", 64'(id_ins), 64'hAAAA0000);
      chk("st_rel_state", 64'(id_state), 64'h1);

      // 4: flush with stall
      flush = 1'b1; stall = 1'b1; tick();
      chk("fl_ins", 64'(id_ins), 64'h0);
      chk("fl_valid", 64'(id_valid), 64'h0);
      chk("fl_pc", 64'(id_pc), 64'h0);
      chk("fl_state", 64'(id_state), 64'h0);
      chk("fl_fcnt", 64'(flush_cnt), 64'h1);
      chk("fl_scnt", 64'(stall_cnt), 64'h3);
      flush = 1'b0;

      // 5: watchdog, stalling on the bubble
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 14) chk("wd_pre", 64'(stall_timeout), 64'h0);
      end
      chk("wd_set", 64'(stall_timeout), 64'h1);
      chk("wd_state", 64'(id_state), 64'h0);
      chk("wd_scnt", 64'(stall_cnt), 64'd18);
      chk("wd_sat_scnt", 64'(s_stall_cnt), 64'h3);
      stall = 1'b0;
      fetch(8'h20, 32'h12345678, 1'b1); tick();
      chk("wd_hold", 64'(stall_timeout), 64'h1);
      chk("wd_load_ins", 64'(id_ins), 64'h12345678);
      chk("wd_load_state", 64'(id_state), 64'h1);
      fetch(8'h24, 32'h0BADF00D, 1'b0); tick();
      chk("inv_state", 64'(id_state), 64'h0);
      chk("inv_valid", 64'(id_valid), 64'h0);
      chk("inv_tmo", 64'(stall_timeout), 64'h1);

      // 6: saturation after a fresh reset
      resetn = 1'b0; tick();
      chk("rst2_tmo", 64'(stall_timeout), 64'h0);
      chk("rst2_sat", 64'(s_stall_cnt), 64'h0);
      resetn = 1'b1; stall = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("sat_cnt", 64'(s_stall_cnt), (i < 3) ? 64'(i) : 64'h3);
      end
      chk("sat_main", 64'(stall_cnt), 64'h5);
      chk("sat_tmo", 64'(stall_timeout), 64'h0);
      stall = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
